// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads the asynchronous instruction ROM,
// and queues fetched words in an in-order buffer for decode (valid/ready).
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 256,
    parameter int unsigned BUF_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [1:0]  state,
    output logic        addr_err
);

    localparam int unsigned   PW       = $clog2(BUF_DEPTH);
    localparam int unsigned   CW       = $clog2(BUF_DEPTH + 1);
    localparam logic [CW-1:0] FULL     = CW'(BUF_DEPTH);
    localparam logic [31:0]   PC_LIMIT = 32'(IMEM_WORDS * 4);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        HALT  = 2'b10,
        FAULT = 2'b11
    } state_t;

    state_t        cur_state, nxt_state;
    logic [31:0]   pc;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   buf_pc    [BUF_DEPTH];
    logic [31:0]   buf_instr [BUF_DEPTH];
    logic          pop, push, flush, fault;

    function automatic logic bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= PC_LIMIT);
    endfunction

    assign pop = id_valid && id_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        push      = 1'b0;
        flush     = 1'b0;
        fault     = 1'b0;
        unique case (cur_state)
            IDLE: begin
                if (start) nxt_state = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    fault = bad_addr(redirect_pc);
                end else begin
                    fault = bad_addr(pc);
                    // halt blocks the fetch in its own cycle so the PC parks at the halt point
                    push  = !fault && !halt && ((count != FULL) || pop);
                end
                if (fault)     nxt_state = FAULT;
                else if (halt) nxt_state = HALT;
            end
            HALT: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    fault = bad_addr(redirect_pc);
                end
                if (fault)                nxt_state = FAULT;
                else if (start && !halt)  nxt_state = RUN;
            end
            FAULT: begin
                nxt_state = FAULT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            addr_err <= 1'b0;
        end else begin
            if (fault) addr_err <= 1'b1;
            if (flush) begin
                // a pop in this cycle is simply dropped from the pointers along with everything else
                pc     <= redirect_pc;
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                    pc     <= pc + 32'd4;
                end
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr]    <= pc;
            buf_instr[wr_ptr] <= imem_instr;
        end
    end

    assign imem_addr   = pc;
    assign id_valid    = (count != '0);
    assign id_instr    = id_valid ? buf_instr[rd_ptr] : '0;
    assign id_pc       = id_valid ? buf_pc[rd_ptr] : '0;
    assign id_pc_plus4 = id_pc + 32'd4;
    assign state       = cur_state;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: queue-based fetch model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_instr_fetch_ctrl;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned WORDS = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        id_valid;
    logic        id_ready = 1'b1;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [1:0]  state;
    logic        addr_err;

    logic [31:0] rom [WORDS];

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] last_pc = '0;

    always #5 clk = ~clk;

    instr_fetch_ctrl #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (WORDS),
        .BUF_DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .state          (state),
        .addr_err       (addr_err)
    );

    assign imem_instr = rom[imem_addr[9:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    localparam int unsigned S_IDLE = 0, S_RUN = 1, S_HALT = 2, S_FAULT = 3;

    ent_t        q[$];
    logic [31:0] m_pc = '0;
    int unsigned m_st = S_IDLE;
    logic        m_err = 1'b0;

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (a < WORDS * 4);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc  = '0;
            m_st  = S_IDLE;
            m_err = 1'b0;
            q.delete();
        end else begin
            ent_t e;
            e.pc    = m_pc;
            e.instr = rom[m_pc[9:2]];
            if (q.size() != 0 && id_ready) void'(q.pop_front());
            if ((m_st == S_RUN || m_st == S_HALT) && redirect_valid) begin
                q.delete();
                m_pc = redirect_pc;
                if (!legal(redirect_pc)) begin
                    m_st  = S_FAULT;
                    m_err = 1'b1;
                end
            end else if (m_st == S_RUN) begin
                if (!legal(m_pc)) begin
                    m_st  = S_FAULT;
                    m_err = 1'b1;
                end else if (!halt && q.size() < DEPTH) begin
                    q.push_back(e);
                    m_pc = m_pc + 32'd4;
                end
            end
            if (m_st == S_IDLE && start)                     m_st = S_RUN;
            else if (m_st == S_RUN && halt)                  m_st = S_HALT;
            else if (m_st == S_HALT && start && !halt)       m_st = S_RUN;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic [31:0] e_pc, e_instr;
            e_pc    = (q.size() != 0) ? q[0].pc : 32'h0;
            e_instr = (q.size() != 0) ? q[0].instr : 32'h0;
            chk("m_valid",   {31'd0, id_valid}, {31'd0, q.size() != 0});
            chk("m_pc",      id_pc, e_pc);
            chk("m_instr",   id_instr, e_instr);
            chk("m_plus4",   id_pc_plus4, e_pc + 32'd4);
            chk("m_addr",    imem_addr, m_pc);
            chk("m_state",   {30'd0, state}, m_st);
            chk("m_err",     {31'd0, addr_err}, {31'd0, m_err});
            if (id_valid && id_ready) last_pc = id_pc;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic nclk(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) rom[i] = 32'h1000_0000 + i;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nclk(2);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_pc",    id_pc, 32'h0);
        chk("rst_instr", id_instr, 32'h0);
        chk("rst_plus4", id_pc_plus4, 32'h4);
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_addr",  imem_addr, 32'h0);
        chk("rst_err",   {31'd0, addr_err}, 32'd0);
        rst_n = 1'b1;
        nclk(1);

        // start, first fetch, then stall decode
        start = 1'b1; nclk(1); start = 1'b0;
        chk("start_state", {30'd0, state}, 32'd1);
        chk("start_empty", {31'd0, id_valid}, 32'd0);
        nclk(1);
        chk("first_pc",    id_pc, 32'h0);
        chk("first_instr", id_instr, 32'h1000_0000);
        chk("first_plus4", id_pc_plus4, 32'h4);
        id_ready = 1'b0; nclk(5);
        chk("stall_addr", imem_addr, 32'h8);
        chk("stall_head", id_pc, 32'h0);
        id_ready = 1'b1; nclk(1);
        chk("rel_pc1",    id_pc, 32'h4);
        chk("rel_instr1", id_instr, 32'h1000_0001);
        nclk(1);
        chk("rel_pc2",    id_pc, 32'h8);
        chk("rel_instr2", id_instr, 32'h1000_0002);
        chk("rel_addr",   imem_addr, 32'h10);

        // redirect with full buffer
        redirect_valid = 1'b1; redirect_pc = 32'h40; nclk(1); redirect_valid = 1'b0;
        chk("redir_flush", {31'd0, id_valid}, 32'd0);
        chk("redir_addr",  imem_addr, 32'h40);
        nclk(1);
        chk("redir_pc",    id_pc, 32'h40);
        chk("redir_instr", id_instr, 32'h1000_0010);

        // halt at pc 0x10
        redirect_valid = 1'b1; redirect_pc = 32'h8; nclk(1); redirect_valid = 1'b0;
        nclk(2);
        chk("pre_halt_addr", imem_addr, 32'h10);
        halt = 1'b1; nclk(1); halt = 1'b0;
        chk("halt_state", {30'd0, state}, 32'd2);
        chk("halt_addr",  imem_addr, 32'h10);
        chk("halt_drain", {31'd0, id_valid}, 32'd0);
        nclk(2);
        chk("halt_hold", imem_addr, 32'h10);
        start = 1'b1; halt = 1'b1; nclk(1); start = 1'b0; halt = 1'b0;
        chk("halt_prio", {30'd0, state}, 32'd2);
        start = 1'b1; nclk(1); start = 1'b0;
        chk("resume_state", {30'd0, state}, 32'd1);
        nclk(1);
        chk("resume_pc",    id_pc, 32'h10);
        chk("resume_instr", id_instr, 32'h1000_0004);

        // misaligned redirect faults
        redirect_valid = 1'b1; redirect_pc = 32'h402; nclk(1); redirect_valid = 1'b0;
        chk("flt_state", {30'd0, state}, 32'd3);
        chk("flt_err",   {31'd0, addr_err}, 32'd1);
        chk("flt_flush", {31'd0, id_valid}, 32'd0);
        chk("flt_addr",  imem_addr, 32'h402);
        start = 1'b1; nclk(1); start = 1'b0;
        chk("flt_start_ign", {30'd0, state}, 32'd3);

        // async reset mid-RUN with a full buffer
        rst_n = 1'b0; nclk(1); rst_n = 1'b1; id_ready = 1'b0;
        start = 1'b1; nclk(1); start = 1'b0;
        nclk(2);
        chk("full_valid", {31'd0, id_valid}, 32'd1);
        chk("full_addr",  imem_addr, 32'h8);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", {30'd0, state}, 32'd0);
        chk("arst_valid", {31'd0, id_valid}, 32'd0);
        chk("arst_addr",  imem_addr, 32'h0);
        chk("arst_pc",    id_pc, 32'h0);
        chk("arst_instr", id_instr, 32'h0);
        chk("arst_plus4", id_pc_plus4, 32'h4);
        chk("arst_err",   {31'd0, addr_err}, 32'd0);
        nclk(1); rst_n = 1'b1; id_ready = 1'b1;

        // sequential run off the end of memory
        start = 1'b1; nclk(1); start = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h3F0; nclk(1); redirect_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (state == 2'b11) break;
            nclk(1);
        end
        chk("end_state", {30'd0, state}, 32'd3);
        chk("end_err",   {31'd0, addr_err}, 32'd1);
        chk("end_addr",  imem_addr, 32'h400);
        chk("end_last",  last_pc, 32'h3FC);
        chk("end_empty", {31'd0, id_valid}, 32'd0);
        start = 1'b1; nclk(1); start = 1'b0;
        chk("end_start_ign", {30'd0, state}, 32'd3);
        nclk(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Fetch sequencer for the single-cycle datapath's instruction memory, which is a 256-word, asynchronous-read, word-indexed ROM.
- Owns the PC and drives the word address to the memory.
- Captures each returned instruction into a small in-order buffer and presents it to decode with a valid/ready handshake.
- Handles start/halt control, branch/jump redirects with flush, and address faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 256, instruction memory depth in words; legal PCs are 0 .. IMEM_WORDS*4-4.
- BUF_DEPTH, 2, fetch buffer entries; power of two, >=2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  pulse; IDLE/HALT -> RUN.
- halt  in  1  pulse; RUN -> HALT.
- redirect_valid  in  1  branch/jump taken; load redirect_pc and flush.
- redirect_pc  in  32  redirect target byte address.
- imem_addr  out  32  byte address to the instruction memory; the memory indexes by addr>>2.
- imem_instr  in  32  instruction word, valid in the same cycle as imem_addr.
- id_valid  out  1  buffer head is valid.
- id_ready  in  1  decode accepts the head.
- id_instr  out  32  head instruction.
- id_pc  out  32  head PC.
- id_pc_plus4  out  32  head PC + 4, mod 2^32.
- state  out  2  IDLE=00, RUN=01, HALT=10, FAULT=11.
- addr_err  out  1  sticky fault flag.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: pc=RESET_PC, state=IDLE, count=0, rd_ptr=wr_ptr=0, id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=4, addr_err=0.
- Reset mid-operation discards buffer contents immediately; no handshake completes.
- imem_addr = pc, combinational from the PC register.
- Pop: occurs when id_valid && id_ready.
- Outputs: id_valid = (count!=0). id_instr, id_pc and id_pc_plus4 come from the head entry; they are 0/0/4 when empty.
- Push: occurs in RUN when (count<BUF_DEPTH || pop) and no redirect. It writes {pc, imem_instr} at wr_ptr and sets pc <= pc+4 (mod 2^32).
- Push+pop in the same cycle leaves count unchanged. Full buffer with no pop means no push and pc holds.
- Pointers wrap modulo BUF_DEPTH.
- Redirect (RUN or HALT):
  - pc <= redirect_pc; count, rd_ptr and wr_ptr clear; no push that cycle.
  - A pop in the same cycle completes; decode owns that instruction.
- Fault check: applies to the pc in RUN before a push, and to redirect_pc when a redirect occurs. Fault if pc[1:0]!=0 or pc >= IMEM_WORDS*4.
  - Fault action: state <= FAULT, addr_err <= 1, no push.
  - The buffer keeps draining normally.
  - A faulting redirect still flushes the buffer and loads pc.
- FSM transitions:
  - IDLE: start -> RUN; everything else ignored.
  - RUN: fault -> FAULT; else halt -> HALT; otherwise stay in RUN.
  - HALT: no pushes; buffer drains. start -> RUN, resuming at the current pc. halt is ignored.
  - FAULT: no pushes. Exits only via reset; start, halt and redirect are ignored.
- Priorities within one cycle: fault > halt > start.
  - redirect+halt in RUN: redirect is applied, then state=HALT.
  - start+halt in HALT: halt wins, stay in HALT.
- Latency:
  - start sampled at edge N -> RUN after N.
  - First push at edge N+1 -> id_valid=1 with id_pc=RESET_PC after N+1.
  - Redirect sampled at edge M -> target instruction on id_* after M+1.
- Throughput: 1 instruction/cycle with id_ready held high.

Test Plan:
- Reset, start, id_ready=1, memory word i = 32'h1000_0000+i -> from cycle 2 on, id_pc = 0,4,8,... and id_instr = 10000000,10000001,... one per cycle; id_pc_plus4 = id_pc+4.
- id_ready=0 for 5 cycles after the first valid -> count saturates at 2, imem_addr holds 8. On release, PCs 0,4,8 are delivered in order with no loss or duplicates.
- redirect_valid with redirect_pc=32'h40 while the buffer is full and id_ready=1 -> the head pops once, the buffer flushes, and the next id_pc=32'h40 one cycle later with id_instr=memory[16].
- halt at pc=32'h10 -> state=10, buffer drains, imem_addr stays 32'h10. start -> resumes with id_pc=32'h10. Also drive start+halt together while in HALT -> stays in HALT.
- Redirect to 32'h402 -> state=11 and addr_err=1, buffer flushed. Run sequentially up to pc=32'h400 -> FAULT after the last valid word (pc 32'h3FC) is delivered. start is ignored in FAULT.
- Assert rst_n low mid-RUN with count=2 -> outputs immediately return to reset values, state=00, pc=RESET_PC.
